// File: rtl/osc_multi_capture.sv
`timescale 1ns/1ps
// osc_multi_capture
// Multi-channel oscilloscope capture engine.
// - Stores CH_NUM ADC channels side by side in a circular buffer.
// - Fills a pre-trigger window, then waits for a level-crossing trigger on
//   the selected channel.
// - Captures the post-trigger remainder, then plays the whole record back
//   in time order.
//
// Ports
//   Clk, Reset_n         : clock, synchronous active-low reset
//   AD_Data, AD_Valid    : ADC samples, channel c in [c*DATA_W +: DATA_W]
//   Arm, Abort           : start capture (IDLE only) / return to IDLE
//   Trig_Ch, Trig_Level,
//   Trig_Mode, Pre_Len   : capture configuration, latched at Arm
//   Rd_Req               : request next readout sample
//   Rd_Data, Rd_Valid,
//   Rd_Last              : readout sample (1-cycle latency), last-sample flag
//   Busy, Triggered, Done: status
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for Arm
// PRE       | filling the pre-trigger window, trigger ignored
// WAIT_TRIG | writing samples, evaluating the trigger
// POST      | writing the post-trigger remainder
// READ      | playing the record back, AD_Valid ignored
module osc_multi_capture #(
  parameter int DATA_W = 8,
  parameter int CH_NUM = 4,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [CH_NUM*DATA_W-1:0] AD_Data,
  input  logic                     AD_Valid,
  input  logic                     Arm,
  input  logic                     Abort,
  input  logic [CH_W-1:0]          Trig_Ch,
  input  logic [DATA_W-1:0]        Trig_Level,
  input  logic [1:0]               Trig_Mode,
  input  logic [ADDR_W-1:0]        Pre_Len,
  input  logic                     Rd_Req,
  output logic [CH_NUM*DATA_W-1:0] Rd_Data,
  output logic                     Rd_Valid,
  output logic                     Rd_Last,
  output logic                     Busy,
  output logic                     Triggered,
  output logic                     Done
);

  localparam int SAMP_W = CH_NUM * DATA_W;
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  localparam logic [1:0] MODE_RISE  = 2'b00;
  localparam logic [1:0] MODE_FALL  = 2'b01;
  localparam logic [1:0] MODE_EDGE  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_TRIG,
    S_POST,
    S_READ
  } state_t;

  state_t state;

  logic [SAMP_W-1:0] mem [DEPTH];

  logic [CH_W-1:0]   cfg_ch;
  logic [DATA_W-1:0] cfg_level;
  logic [1:0]        cfg_mode;
  // Pre_Len is ADDR_W bits wide, so it can never exceed DEPTH-1.
  logic [ADDR_W-1:0] cfg_pre;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] trig_addr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  rd_cnt;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;

  logic [DATA_W-1:0] cur;
  logic              capturing;
  logic              wr_en;
  logic              rd_en;
  logic              rise_hit;
  logic              fall_hit;
  logic              trig_hit;
  logic [CNT_W-1:0]  post_len;

  // Trigger-channel sample of the incoming word. Out-of-range selects read 0.
  always_comb begin
    cur = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (cfg_ch == CH_W'(c)) cur = AD_Data[c*DATA_W +: DATA_W];
    end
  end

  assign capturing = (state == S_PRE) || (state == S_WAIT_TRIG) || (state == S_POST);
  assign wr_en     = capturing && AD_Valid && !Abort;
  // rd_cnt == DEPTH marks the one-cycle tail after the last read issue.
  assign rd_en     = (state == S_READ) && Rd_Req && (rd_cnt != DEPTH_C) && !Abort;

  assign rise_hit  = prev_valid && (prev < cfg_level) && (cur >= cfg_level);
  assign fall_hit  = prev_valid && (prev > cfg_level) && (cur <= cfg_level);
  assign post_len  = DEPTH_C - ONE_C - {1'b0, cfg_pre};

  always_comb begin
    trig_hit = 1'b0;
    case (cfg_mode)
      MODE_RISE: trig_hit = rise_hit;
      MODE_FALL: trig_hit = fall_hit;
      MODE_EDGE: trig_hit = rise_hit || fall_hit;
      default:   trig_hit = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr] <= AD_Data;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n)   Rd_Data <= '0;
    else if (rd_en) Rd_Data <= mem[rd_ptr];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      cfg_ch     <= '0;
      cfg_level  <= '0;
      cfg_mode   <= '0;
      cfg_pre    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      trig_addr  <= '0;
      count      <= '0;
      remaining  <= '0;
      rd_cnt     <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      Rd_Valid   <= 1'b0;
      Rd_Last    <= 1'b0;
      Busy       <= 1'b0;
      Triggered  <= 1'b0;
      Done       <= 1'b0;
    end else begin
      Done     <= 1'b0;
      Rd_Valid <= 1'b0;
      Rd_Last  <= 1'b0;
      if (Abort) begin
        state     <= S_IDLE;
        Busy      <= 1'b0;
        Triggered <= 1'b0;
      end else begin
        // Common bookkeeping for every written sample.
        if (wr_en) begin
          wr_ptr     <= wr_ptr + 1'b1;
          prev       <= cur;
          prev_valid <= 1'b1;
        end
        case (state)
          S_IDLE: begin
            if (Arm) begin
              cfg_ch     <= Trig_Ch;
              cfg_level  <= Trig_Level;
              cfg_mode   <= Trig_Mode;
              cfg_pre    <= Pre_Len;
              wr_ptr     <= '0;
              count      <= '0;
              prev_valid <= 1'b0;
              Triggered  <= 1'b0;
              Busy       <= 1'b1;
              state      <= (Pre_Len == '0) ? S_WAIT_TRIG : S_PRE;
            end
          end
          S_PRE: begin
            if (AD_Valid) begin
              count <= count + ONE_C;
              if (count + ONE_C == {1'b0, cfg_pre}) state <= S_WAIT_TRIG;
            end
          end
          S_WAIT_TRIG: begin
            if (AD_Valid && trig_hit) begin
              Triggered <= 1'b1;
              trig_addr <= wr_ptr;
              remaining <= post_len;
              if (post_len == '0) begin
                // Pre-window fills the whole buffer: record is complete now.
                state  <= S_READ;
                rd_ptr <= wr_ptr - cfg_pre;
                rd_cnt <= '0;
              end else begin
                state <= S_POST;
              end
            end
          end
          S_POST: begin
            if (AD_Valid) begin
              remaining <= remaining - ONE_C;
              if (remaining == ONE_C) begin
                state  <= S_READ;
                rd_ptr <= trig_addr - cfg_pre;
                rd_cnt <= '0;
              end
            end
          end
          S_READ: begin
            if (rd_cnt == DEPTH_C) begin
              // Last sample was presented last cycle; close out the record.
              state     <= S_IDLE;
              Busy      <= 1'b0;
              Triggered <= 1'b0;
              Done      <= 1'b1;
            end else if (Rd_Req) begin
              rd_ptr   <= rd_ptr + 1'b1;
              rd_cnt   <= rd_cnt + ONE_C;
              Rd_Valid <= 1'b1;
              Rd_Last  <= (rd_cnt == DEPTH_C - ONE_C);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_osc_multi_capture.sv
`timescale 1ns/1ps
// Directed bench for osc_multi_capture at DATA_W=8, CH_NUM=4, DEPTH=16.
module tb_osc_multi_capture;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] AD_Data;
  logic        AD_Valid;
  logic        Arm;
  logic        Abort;
  logic [1:0]  Trig_Ch;
  logic [7:0]  Trig_Level;
  logic [1:0]  Trig_Mode;
  logic [3:0]  Pre_Len;
  logic        Rd_Req;
  logic [31:0] Rd_Data;
  logic        Rd_Valid;
  logic        Rd_Last;
  logic        Busy;
  logic        Triggered;
  logic        Done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] stim [0:63];
  logic [31:0] rec  [0:15];

  osc_multi_capture #(
    .DATA_W(8),
    .CH_NUM(4),
    .DEPTH (16)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .AD_Data   (AD_Data),
    .AD_Valid  (AD_Valid),
    .Arm       (Arm),
    .Abort     (Abort),
    .Trig_Ch   (Trig_Ch),
    .Trig_Level(Trig_Level),
    .Trig_Mode (Trig_Mode),
    .Pre_Len   (Pre_Len),
    .Rd_Req    (Rd_Req),
    .Rd_Data   (Rd_Data),
    .Rd_Valid  (Rd_Valid),
    .Rd_Last   (Rd_Last),
    .Busy      (Busy),
    .Triggered (Triggered),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic arm(input logic [3:0] pre, input logic [1:0] mode,
                     input logic [1:0] ch, input logic [7:0] level);
    Pre_Len = pre; Trig_Mode = mode; Trig_Ch = ch; Trig_Level = level;
    Arm = 1'b1;
    @(negedge Clk);
    Arm = 1'b0;
    chk("busy_after_arm", Busy, 1);
    chk("trig_clear_at_arm", Triggered, 0);
  endtask

  // Drive n samples from stim[]; Triggered must be high from the cycle after
  // sample trig_idx is written.
  task automatic feed(input int n, input int trig_idx, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 2)) begin
        AD_Valid = 1'b0; AD_Data = $urandom;
        @(negedge Clk);
      end
      AD_Valid = 1'b1; AD_Data = stim[i];
      @(negedge Clk);
      chk("triggered", Triggered, (i >= trig_idx));
    end
    AD_Valid = 1'b0;
  endtask

  // Read the record back; expected samples are stim[base .. base+15].
  task automatic read_out(input int base, input bit toggle);
    int k, issued, dones, last_cyc;
    bit exp_v, r;
    k = 0; issued = 0; dones = 0; last_cyc = -10; exp_v = 0;
    AD_Valid = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      r = toggle ? (cyc % 2 == 0) : 1'b1;
      Rd_Req  = r;
      AD_Data = $urandom;
      exp_v = r && (issued < 16);
      if (exp_v) issued++;
      @(negedge Clk);
      chk("rd_valid", Rd_Valid, exp_v);
      if (Rd_Valid && k < 16) begin
        rec[k] = Rd_Data;
        chk("rd_data", Rd_Data, stim[base+k]);
        chk("rd_last", Rd_Last, (k == 15));
        if (k == 15) last_cyc = cyc;
        k++;
      end else if (!Rd_Valid && k > 0 && k < 16) begin
        chk("rd_hold", Rd_Data, rec[k-1]);
      end
      if (Done) begin
        dones++;
        chk("done_timing", cyc, last_cyc + 1);
        chk("busy_at_done", Busy, 0);
      end
    end
    Rd_Req = 1'b0; AD_Valid = 1'b0;
    chk("rd_count", k, 16);
    chk("done_once", dones, 1);
  endtask

  task automatic fill_force();
    for (int i = 0; i < 64; i++) begin
      logic [7:0] c0, c1, c2, c3;
      c0 = 8'h30 + 8'(i); c1 = 8'(i * 5); c2 = 8'h80 ^ 8'(i); c3 = 8'hFF - 8'(i);
      stim[i] = {c3, c2, c1, c0};
    end
  endtask

  initial begin
    Reset_n = 1'b0; AD_Data = '0; AD_Valid = 1'b0; Arm = 1'b0; Abort = 1'b0;
    Trig_Ch = '0; Trig_Level = '0; Trig_Mode = '0; Pre_Len = '0; Rd_Req = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_rd_data", Rd_Data, 0);
    chk("rst_rd_valid", Rd_Valid, 0);
    chk("rst_rd_last", Rd_Last, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_triggered", Triggered, 0);
    chk("rst_done", Done, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Reset during POST: force, Pre_Len=4, trigger at sample 4, stop at sample 6.
    fill_force();
    arm(4'd4, 2'b11, 2'd0, 8'h00);
    feed(7, 4, 1'b0);
    chk("post_busy", Busy, 1);
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("rpost_busy", Busy, 0);
    chk("rpost_triggered", Triggered, 0);
    chk("rpost_done", Done, 0);
    chk("rpost_rd_valid", Rd_Valid, 0);
    chk("rpost_rd_last", Rd_Last, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Rising on ch2 ramp, L=0x80, Pre_Len=4: trigger at sample 8 (0x70->0x80).
    for (int i = 0; i < 64; i++) begin
      logic [7:0] c0, c1, c2, c3;
      c0 = 8'(i); c1 = 8'hA0 + 8'(i); c2 = 8'(i * 16); c3 = 8'(i) ^ 8'h55;
      stim[i] = {c3, c2, c1, c0};
    end
    arm(4'd4, 2'b00, 2'd2, 8'h80);
    feed(20, 8, 1'b1);
    chk("rise_busy", Busy, 1);
    read_out(4, 1'b0);
    chk("rise_trig_sample_ch2", {24'h0, rec[4][23:16]}, 32'h80);

    // Falling on ch0, L=0x40, Pre_Len=4, edge at sample 40 (pointer wrapped).
    // ch0 rises at 20 (ignored in falling mode); ch3 falls at 12 (wrong channel).
    for (int i = 0; i < 64; i++) begin
      logic [7:0] c0, c1, c2, c3;
      c0 = (i < 20) ? 8'h00 : (i < 40) ? 8'hC0 : (i == 40) ? 8'h40 : 8'h20;
      c1 = 8'(i);
      c2 = ~8'(i);
      c3 = (i == 12) ? 8'h00 : 8'hC0;
      stim[i] = {c3, c2, c1, c0};
    end
    arm(4'd4, 2'b01, 2'd0, 8'h40);
    feed(52, 40, 1'b0);
    read_out(36, 1'b0);
    chk("fall_pre_last_ch0", {24'h0, rec[3][7:0]}, 32'hC0);
    chk("fall_trig_ch0", {24'h0, rec[4][7:0]}, 32'h40);

    // Force with Pre_Len=0: trigger on first sample; toggled Rd_Req readout.
    fill_force();
    arm(4'd0, 2'b11, 2'd1, 8'h00);
    feed(16, 0, 1'b0);
    read_out(0, 1'b1);

    // Force with Pre_Len=DEPTH-1: no POST phase at all.
    arm(4'd15, 2'b11, 2'd3, 8'h00);
    feed(16, 15, 1'b1);
    read_out(0, 1'b0);

    // Abort in WAIT_TRIG; a second Arm while busy must be ignored.
    for (int i = 0; i < 64; i++) stim[i] = {8'h11, 8'h22, 8'h33, 8'h00};
    arm(4'd2, 2'b00, 2'd0, 8'hFF);
    feed(5, 99, 1'b0);
    Pre_Len = 4'd0; Trig_Mode = 2'b11;
    Arm = 1'b1;
    @(negedge Clk);
    Arm = 1'b0;
    chk("rearm_busy", Busy, 1);
    feed(3, 99, 1'b0);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    chk("abort_busy", Busy, 0);
    chk("abort_triggered", Triggered, 0);
    Rd_Req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("idle_rd_valid", Rd_Valid, 0);
      chk("abort_no_done", Done, 0);
    end
    Rd_Req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
